eoc_column_reader: RTL

// End-of-column readout for one double column of super pixels. Drives the column's

---
 rtl/eoc_column_reader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/eoc_column_reader.sv
// End-of-column readout for one double column: acknowledges each valid column
// word, tags it with the column address, buffers it in a FWFT FIFO and hands it
// to the periphery serializer over a valid/ready handshake.
`timescale 1ns/1ps

module eoc_column_reader #(
    parameter int FIFO_DEPTH = 8,
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 16
) (
    input  logic                          clk_40MHz,
    input  logic                          rst_n,
    input  logic                          read_en,
    input  logic [1:0]                    col_addr,
    input  logic [25:0]                   col_data,
    output logic                          shake_hands_col,
    output logic [26:0]                   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              hit_cnt,
    input  logic                          cnt_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);
    localparam logic [LVL_W-1:0] LEVEL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACK    = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [SET_W-1:0]  settle_cnt;
    logic [SET_W-1:0]  settle_next;
    logic              capture;
    logic              pop;
    logic              full;

    logic [26:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Full is judged on the registered level so a same-cycle pop never frees a slot early
    assign full      = (fifo_level == LEVEL_FULL);
    assign out_valid = (fifo_level != '0);
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Next-state logic: capture only from IDLE, then one ACK cycle, then settle countdown
    always_comb begin
        state_next  = state;
        settle_next = settle_cnt;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (read_en && col_data[25] && !full) begin
                    capture    = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next  = SETTLE;
                settle_next = SETTLE_LOAD;
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    settle_next = settle_cnt - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, settle counter and the registered acknowledge (high exactly while in ACK)
    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            settle_cnt      <= '0;
            shake_hands_col <= 1'b0;
        end else begin
            state           <= state_next;
            settle_cnt      <= settle_next;
            shake_hands_col <= (state_next == ACK);
        end
    end

    // FIFO storage; contents need no reset because out_data is gated by out_valid
    always_ff @(posedge clk_40MHz) begin
        if (capture) begin
            mem[wr_ptr] <= {col_addr, col_data[24:0]};
        end
    end

    // FIFO pointers (wrap naturally at power-of-2 depth) and separate occupancy counter
    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({capture, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Saturating capture counter; clear takes priority over a same-cycle capture
    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt <= '0;
        end else if (cnt_clr) begin
            hit_cnt <= '0;
        end else if (capture && (hit_cnt != '1)) begin
            hit_cnt <= hit_cnt + 1'b1;
        end
    end

endmodule
